conf_systolic: RTL and testbench
================================

# conf_systolic

Dual-lane multiply-accumulate cell for the sparse matrix-vector datapath. Each lane takes one nonzero matrix value with its row index and a row-start tag, multiplies it by a shared vector element, and accumulates per row. The cell also flags when both lanes target the same row in the same cycle (`overlap`) so the downstream merger can combine their partial products. It sits between the nonzero-stream distributor and the row-result collector.

## Interface
Parameters:
- none; all widths are fixed: value/vector 32 bits, row index 12 bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `val1`, `val2`  in  32  matrix values for lanes 1 and 2, unsigned; 0 means the lane is idle this cycle.
- `rowIdx1`, `rowIdx2`  in  12  row index of each lane's value.
- `tag1`, `tag2`  in  1  row-start tag; 1 means this value is the first element of a new row.
- `vec`  in  32  vector element, broadcast to both lanes.
- `overlap`  out  1  registered; both lanes were active on the same row in the previous cycle.
- `acc1`, `acc2`  out  32  registered per-lane row accumulators.
- `merge`  out  32  registered sum of both lanes' products on an overlap cycle, else 0.

## Operation
- Lane i is active when `val_i` != 0. Product `p_i` = (`val_i` × `vec`)[31:0]: unsigned, truncated to the low 32 bits.
- Active lane with `tag_i`=1: `acc_i` <= `p_i` (new row, previous total discarded).
- Active lane with `tag_i`=0: `acc_i` <= `acc_i` + `p_i`, mod 2^32.
- Idle lane: `acc_i` holds; `tag_i` and `rowIdx_i` are ignored.
- Overlap condition: both lanes active and `rowIdx1` == `rowIdx2`. Tags do not affect it.
- `overlap` <= overlap condition.
- `merge` <= (`p1` + `p2`) mod 2^32 when the overlap condition is true, else 0.
- Per-lane accumulation is unaffected by overlap; both lanes still update `acc1` and `acc2`.
- No handshake, no stall, no state machine. The cell accepts one input pair every cycle.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on all outputs after edge N.
- `reset` high, asynchronously: `overlap`=0, `acc1`=`acc2`=0, `merge`=0. These values hold while `reset` is high.
- Reset asserted mid-stream discards the accumulators. The first input after release accumulates from 0 when its tag is 0.
- Inputs held constant across several edges are consumed once per edge. With tag=0 the accumulator grows on every edge.
- Multiplier and adders are combinational within one cycle; no pipelining.

## Test plan
- Reset: assert `reset` with nonzero inputs and the clock running. Required: all outputs are 0 immediately, before any clock edge, and stay 0 until release.
- Case 1, from reset: `val1`=0xABCDE, `val2`=0x54321, `vec`=0x1234, `rowIdx1`=0x123, `rowIdx2`=0x456, `tag1`=1, `tag2`=0.
  - After 1 edge: `acc1`=0xC375F918, `acc2`=0x5FC9F4B4, `overlap`=0, `merge`=0.
  - After a 2nd edge with inputs held: `acc1` stays 0xC375F918 (tag reload), `acc2`=0xBF93E968.
- Idle lane: `val1`=0, `val2`=0x98765, `rowIdx2`=0x789, `tag2`=1, `vec`=0x5678, applied after Case 1. Required: `acc1` unchanged at 0xC375F918, `acc2`=0x98765×0x5678 mod 2^32, `overlap`=0.
- Overlap: `val1`=3, `val2`=5, `vec`=7, both `rowIdx`=0x010, both tags 1. Required: `overlap`=1, `merge`=0x38, `acc1`=0x15, `acc2`=0x23. Then change `rowIdx2` to 0x011: next cycle `overlap`=0, `merge`=0.
- Overflow: `val1`=0xFFFFFFFF, `vec`=2, `tag1`=1, then `tag1`=0 for one more edge. Required: `acc1`=0xFFFFFFFE, then 0xFFFFFFFC (wraps mod 2^32).
- Both idle: `val1`=`val2`=0 with equal rows. Required: `overlap`=0, `merge`=0, accumulators hold.

Source files
------------

// File: rtl/conf_systolic.sv
// Dual-lane unsigned multiply-accumulate cell with per-lane row accumulators
// and same-row overlap detection for the downstream partial-product merger.
module conf_systolic (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [11:0] rowIdx1,
  input  logic [11:0] rowIdx2,
  input  logic        tag1,
  input  logic        tag2,
  input  logic [31:0] vec,
  output logic        overlap,
  output logic [31:0] acc1,
  output logic [31:0] acc2,
  output logic [31:0] merge
);

  logic [31:0] w_p1;
  logic [31:0] w_p2;
  logic        w_act1;
  logic        w_act2;
  logic        w_ovl;
  logic [31:0] w_acc1_nxt;
  logic [31:0] w_acc2_nxt;

  logic        r_overlap;
  logic [31:0] r_acc1;
  logic [31:0] r_acc2;
  logic [31:0] r_merge;

  // Products are truncated to the low 32 bits by the 32-bit result width.
  assign w_p1   = val1 * vec;
  assign w_p2   = val2 * vec;
  assign w_act1 = |val1;
  assign w_act2 = |val2;
  assign w_ovl  = w_act1 && w_act2 && (rowIdx1 == rowIdx2);

  always_comb begin
    w_acc1_nxt = r_acc1;
    w_acc2_nxt = r_acc2;
    if (w_act1) w_acc1_nxt = tag1 ? w_p1 : r_acc1 + w_p1;
    if (w_act2) w_acc2_nxt = tag2 ? w_p2 : r_acc2 + w_p2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overlap <= 1'b0;
      r_acc1    <= '0;
      r_acc2    <= '0;
      r_merge   <= '0;
    end else begin
      r_overlap <= w_ovl;
      r_acc1    <= w_acc1_nxt;
      r_acc2    <= w_acc2_nxt;
      r_merge   <= w_ovl ? w_p1 + w_p2 : '0;
    end
  end

  assign overlap = r_overlap;
  assign acc1    = r_acc1;
  assign acc2    = r_acc2;
  assign merge   = r_merge;

endmodule

// File: tb/tb_conf_systolic.sv
// Scoreboard bench for conf_systolic: expected outputs are queued as inputs
// are driven and popped once the following clock edge has produced them.
module tb_conf_systolic;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] val1, val2, vec;
  logic [11:0] rowIdx1, rowIdx2;
  logic        tag1, tag2;
  logic        overlap;
  logic [31:0] acc1, acc2, merge;

  typedef struct {
    logic        ov;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] m;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_acc1, m_acc2;
  int          n_tests = 0;
  int          n_fail  = 0;

  conf_systolic dut (
    .clk(clk), .reset(reset),
    .val1(val1), .val2(val2),
    .rowIdx1(rowIdx1), .rowIdx2(rowIdx2),
    .tag1(tag1), .tag2(tag2),
    .vec(vec),
    .overlap(overlap), .acc1(acc1), .acc2(acc2), .merge(merge)
  );

  always #5 clk = ~clk;

  // Drive one input pair and queue the outputs it must produce after the edge.
  task automatic drive(input logic [31:0] v1, input logic [31:0] v2,
                       input logic [11:0] r1, input logic [11:0] r2,
                       input logic t1, input logic t2, input logic [31:0] vc);
    exp_t        e;
    logic [31:0] p1, p2;
    logic        hit;
    val1 = v1; val2 = v2; rowIdx1 = r1; rowIdx2 = r2;
    tag1 = t1; tag2 = t2; vec = vc;
    p1  = v1 * vc;
    p2  = v2 * vc;
    hit = (v1 != 0) && (v2 != 0) && (r1 == r2);
    if (v1 != 0) m_acc1 = t1 ? p1 : m_acc1 + p1;
    if (v2 != 0) m_acc2 = t2 ? p2 : m_acc2 + p2;
    e.ov = hit;
    e.a1 = m_acc1;
    e.a2 = m_acc2;
    e.m  = hit ? p1 + p2 : 32'h0;
    sb.push_back(e);
  endtask

  task automatic tick(output exp_t e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1;
    val1 = 32'h11; val2 = 32'h22; rowIdx1 = 12'h5; rowIdx2 = 12'h5;
    tag1 = 1'b0; tag2 = 1'b0; vec = 32'h3;
    m_acc1 = '0; m_acc2 = '0;
    #2;
    n_tests++;
    if ({overlap, acc1, acc2, merge} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: ov=%b acc1=%h acc2=%h merge=%h, want all 0", overlap, acc1, acc2, merge);
    end
    // Accumulate some nonzero state, then assert reset between edges.
    @(posedge clk); #1;
    reset = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(32'h11 + i, 32'h22, 12'h5, 12'h5, 1'b0, 1'b0, 32'h3);
      tick(e);
      n_tests++;
      if (acc1 !== e.a1 || acc2 !== e.a2 || overlap !== e.ov || merge !== e.m) begin
        n_fail++;
        $display("FAIL prereset_step%0d: ov=%b acc1=%h acc2=%h merge=%h, want ov=%b acc1=%h acc2=%h merge=%h",
                 i, overlap, acc1, acc2, merge, e.ov, e.a1, e.a2, e.m);
      end
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({overlap, acc1, acc2, merge} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: ov=%b acc1=%h acc2=%h merge=%h, want all 0", overlap, acc1, acc2, merge);
    end
    for (int unsigned i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({overlap, acc1, acc2, merge} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold%0d: ov=%b acc1=%h acc2=%h merge=%h, want all 0", i, overlap, acc1, acc2, merge);
      end
    end
    reset = 1'b0;
    sb.delete();
    m_acc1 = '0; m_acc2 = '0;
    // First tag=0 input after release starts from zero.
    drive(32'h6, 32'h0, 12'h1, 12'h2, 1'b0, 1'b0, 32'h7);
    tick(e);
    n_tests++;
    if (acc1 !== 32'h2A || acc1 !== e.a1 || acc2 !== e.a2) begin
      n_fail++;
      $display("FAIL reset_release_acc: acc1=%h acc2=%h, want acc1=%h acc2=%h", acc1, acc2, e.a1, e.a2);
    end
    // Return to a clean state for the directed cases.
    reset = 1'b1; #1 reset = 1'b0;
    sb.delete();
    m_acc1 = '0; m_acc2 = '0;
  endtask

  task automatic test_case1;
    exp_t        e;
    logic [31:0] want1[2] = '{32'hC375F918, 32'hC375F918};
    logic [31:0] want2[2] = '{32'h5FC9F4B4, 32'hBF93E968};
    for (int unsigned i = 0; i < 2; i++) begin
      drive(32'hABCDE, 32'h54321, 12'h123, 12'h456, 1'b1, 1'b0, 32'h1234);
      tick(e);
      n_tests++;
      if (acc1 !== e.a1 || acc2 !== e.a2 || overlap !== e.ov || merge !== e.m) begin
        n_fail++;
        $display("FAIL case1_sb%0d: ov=%b acc1=%h acc2=%h merge=%h, want ov=%b acc1=%h acc2=%h merge=%h",
                 i, overlap, acc1, acc2, merge, e.ov, e.a1, e.a2, e.m);
      end
      n_tests++;
      if (acc1 !== want1[i] || acc2 !== want2[i] || overlap !== 1'b0 || merge !== 32'h0) begin
        n_fail++;
        $display("FAIL case1_const%0d: acc1=%h acc2=%h ov=%b merge=%h, want acc1=%h acc2=%h ov=0 merge=0",
                 i, acc1, acc2, overlap, merge, want1[i], want2[i]);
      end
    end
  endtask

  task automatic test_idle_lane;
    exp_t e;
    drive(32'h0, 32'h98765, 12'h123, 12'h789, 1'b1, 1'b1, 32'h5678);
    tick(e);
    n_tests++;
    if (acc1 !== 32'hC375F918 || acc2 !== e.a2 || overlap !== 1'b0 || merge !== e.m) begin
      n_fail++;
      $display("FAIL idle_lane: acc1=%h acc2=%h ov=%b merge=%h, want acc1=c375f918 acc2=%h ov=0 merge=%h",
               acc1, acc2, overlap, merge, e.a2, e.m);
    end
  endtask

  task automatic test_overlap;
    exp_t        e;
    logic [11:0] r2[2]   = '{12'h010, 12'h011};
    logic        wov[2]  = '{1'b1, 1'b0};
    logic [31:0] wm[2]   = '{32'h38, 32'h0};
    for (int unsigned i = 0; i < 2; i++) begin
      drive(32'd3, 32'd5, 12'h010, r2[i], 1'b1, 1'b1, 32'd7);
      tick(e);
      n_tests++;
      if (overlap !== wov[i] || merge !== wm[i] || acc1 !== 32'h15 || acc2 !== 32'h23 ||
          overlap !== e.ov || merge !== e.m) begin
        n_fail++;
        $display("FAIL overlap%0d: ov=%b merge=%h acc1=%h acc2=%h, want ov=%b merge=%h acc1=15 acc2=23",
                 i, overlap, merge, acc1, acc2, wov[i], wm[i]);
      end
    end
  endtask

  task automatic test_overflow;
    exp_t        e;
    logic        t[2]    = '{1'b1, 1'b0};
    logic [31:0] want[2] = '{32'hFFFFFFFE, 32'hFFFFFFFC};
    for (int unsigned i = 0; i < 2; i++) begin
      drive(32'hFFFFFFFF, 32'h0, 12'h0, 12'h0, t[i], 1'b0, 32'd2);
      tick(e);
      n_tests++;
      if (acc1 !== want[i] || acc1 !== e.a1 || acc2 !== e.a2 || overlap !== 1'b0) begin
        n_fail++;
        $display("FAIL overflow%0d: acc1=%h acc2=%h ov=%b, want acc1=%h acc2=%h ov=0",
                 i, acc1, acc2, overlap, want[i], e.a2);
      end
    end
  endtask

  task automatic test_both_idle;
    exp_t e;
    drive(32'h0, 32'h0, 12'h0AA, 12'h0AA, 1'b1, 1'b1, 32'hFFFF);
    tick(e);
    n_tests++;
    if (overlap !== 1'b0 || merge !== 32'h0 || acc1 !== 32'hFFFFFFFC || acc2 !== e.a2) begin
      n_fail++;
      $display("FAIL both_idle: ov=%b merge=%h acc1=%h acc2=%h, want ov=0 merge=0 acc1=fffffffc acc2=%h",
               overlap, merge, acc1, acc2, e.a2);
    end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    logic [31:0] v1, v2;
    for (int unsigned i = 0; i < 200; i++) begin
      v1 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      v2 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      drive(v1, v2, 12'($urandom_range(0, 3)), 12'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      tick(e);
      n_tests++;
      if (acc1 !== e.a1 || acc2 !== e.a2 || overlap !== e.ov || merge !== e.m) begin
        n_fail++;
        $display("FAIL b2b_%0d: ov=%b acc1=%h acc2=%h merge=%h, want ov=%b acc1=%h acc2=%h merge=%h",
                 i, overlap, acc1, acc2, merge, e.ov, e.a1, e.a2, e.m);
      end
    end
  endtask

  initial begin
    test_reset;
    test_case1;
    test_idle_lane;
    test_overlap;
    test_overflow;
    test_both_idle;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
